// File: rtl/multi_stage_stopwatch_if.sv
// Stopwatch control/status bundle.
// Lap ports exist only with MULTI_STAGE_STOPWATCH_LAP_EN.
interface multi_stage_stopwatch_if #(
  parameter int W = 7
);
  logic         start;
  logic         stop;
  logic         clear;
  logic         mode_down;
  logic         load;
  logic [W-1:0] pre0;
  logic [W-1:0] pre1;
  logic [W-1:0] pre2;
  logic [W-1:0] q0;
  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic [1:0]   state;
  logic         overflow;
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
  logic         lap;
  logic [W-1:0] lap0;
  logic [W-1:0] lap1;
  logic [W-1:0] lap2;
  logic         lap_valid;
`endif

  modport master (
    output start, stop, clear, mode_down, load,
    output pre0, pre1, pre2,
    input  q0, q1, q2, state, overflow
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
    , output lap
    , input lap0, lap1, lap2, lap_valid
`endif
  );

  modport slave (
    input  start, stop, clear, mode_down, load,
    input  pre0, pre1, pre2,
    output q0, q1, q2, state, overflow
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
    , input lap
    , output lap0, lap1, lap2, lap_valid
`endif
  );
endinterface

// File: rtl/multi_stage_stopwatch.sv
// Three-stage up/down stopwatch with IDLE/RUN/PAUSE/LOCK control.
// Optional lap capture: define MULTI_STAGE_STOPWATCH_LAP_EN.
module multi_stage_stopwatch #(
  parameter int DIV_MAX = 250000,
  parameter int W       = 7,
  parameter int LIM0    = 100,
  parameter int LIM1    = 60,
  parameter int LIM2    = 60
) (
  input logic                    clk,
  input logic                    rst_hw,
  multi_stage_stopwatch_if.slave sw
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LOCK  = 2'b11
  } st_t;

  localparam int DW = 18;
  localparam logic [DW-1:0] DIV_TOP = DW'(DIV_MAX - 1);
  localparam logic [W-1:0]  T0 = W'(LIM0 - 1);
  localparam logic [W-1:0]  T1 = W'(LIM1 - 1);
  localparam logic [W-1:0]  T2 = W'(LIM2 - 1);
  localparam logic [W:0]    L0 = (W+1)'(LIM0);
  localparam logic [W:0]    L1 = (W+1)'(LIM1);
  localparam logic [W:0]    L2 = (W+1)'(LIM2);

  function automatic logic [W-1:0] nxt(
    input logic [W-1:0] v,
    input logic [W-1:0] top,
    input logic         dn
  );
    if (dn) return (v == '0) ? top : v - 1'b1;
    else    return (v == top) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [W-1:0] clamp(
    input logic [W-1:0] p,
    input logic [W:0]   lim,
    input logic [W-1:0] top
  );
    return ({1'b0, p} >= lim) ? top : p;
  endfunction

  st_t           st_q, st_n;
  logic [DW-1:0] div_q, div_n, div_t;
  logic [W-1:0]  q0_q, q1_q, q2_q;
  logic [W-1:0]  q0_n, q1_n, q2_n;
  logic [W-1:0]  q0_t, q1_t, q2_t;
  logic          down_q, down_n;
  logic          ovf_q;
  logic          term, tick, c0, c1;

  always_comb begin
    term = down_q ? (q0_q == '0 && q1_q == '0 && q2_q == '0)
                  : (q0_q == T0 && q1_q == T1 && q2_q == T2);
    tick = (st_q == RUN) && !term && (div_q == DIV_TOP);
    c0   = down_q ? (q0_q == '0) : (q0_q == T0);
    c1   = c0 && (down_q ? (q1_q == '0) : (q1_q == T1));
    q0_t = tick ? nxt(q0_q, T0, down_q) : q0_q;
    q1_t = (tick && c0) ? nxt(q1_q, T1, down_q) : q1_q;
    q2_t = (tick && c1) ? nxt(q2_q, T2, down_q) : q2_q;
    // Divider freezes once terminal so LOCK is entered with it held.
    if (st_q == RUN && !term)
      div_t = (div_q == DIV_TOP) ? '0 : div_q + 1'b1;
    else
      div_t = div_q;
  end

`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
  logic [W-1:0] l0_q, l1_q, l2_q;
  logic [W-1:0] l0_n, l1_n, l2_n;
  logic         lv_q, lv_n;
`endif

  always_comb begin
    st_n   = st_q;
    div_n  = div_q;
    q0_n   = q0_q;
    q1_n   = q1_q;
    q2_n   = q2_q;
    down_n = down_q;
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
    l0_n   = l0_q;
    l1_n   = l1_q;
    l2_n   = l2_q;
    lv_n   = lv_q;
`endif
    if (sw.clear) begin
      st_n  = IDLE;
      div_n = '0;
      q0_n  = '0;
      q1_n  = '0;
      q2_n  = '0;
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
      l0_n  = '0;
      l1_n  = '0;
      l2_n  = '0;
      lv_n  = 1'b0;
`endif
    end else begin
      unique case (st_q)
        IDLE: begin
          if (sw.start) begin
            st_n   = RUN;
            down_n = sw.mode_down;
          end else if (sw.load) begin
            q0_n = clamp(sw.pre0, L0, T0);
            q1_n = clamp(sw.pre1, L1, T1);
            q2_n = clamp(sw.pre2, L2, T2);
          end
        end
        RUN: begin
          q0_n  = q0_t;
          q1_n  = q1_t;
          q2_n  = q2_t;
          div_n = div_t;
          if (term)         st_n = LOCK;
          else if (sw.stop) st_n = PAUSE;
        end
        PAUSE: begin
          if (sw.start) st_n = RUN;
        end
        LOCK: begin
          st_n = LOCK;
        end
      endcase
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
      if (sw.lap && (st_q == RUN || st_q == PAUSE)) begin
        l0_n = q0_n;
        l1_n = q1_n;
        l2_n = q2_n;
        lv_n = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst_hw) begin
      st_q   <= IDLE;
      div_q  <= '0;
      q0_q   <= '0;
      q1_q   <= '0;
      q2_q   <= '0;
      down_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_n;
      div_q  <= div_n;
      q0_q   <= q0_n;
      q1_q   <= q1_n;
      q2_q   <= q2_n;
      down_q <= down_n;
      ovf_q  <= (st_n == LOCK);
    end
  end

`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (rst_hw) begin
      l0_q <= '0;
      l1_q <= '0;
      l2_q <= '0;
      lv_q <= 1'b0;
    end else begin
      l0_q <= l0_n;
      l1_q <= l1_n;
      l2_q <= l2_n;
      lv_q <= lv_n;
    end
  end

  assign sw.lap0      = l0_q;
  assign sw.lap1      = l1_q;
  assign sw.lap2      = l2_q;
  assign sw.lap_valid = lv_q;
`endif

  assign sw.q0       = q0_q;
  assign sw.q1       = q1_q;
  assign sw.q2       = q2_q;
  assign sw.state    = st_q;
  assign sw.overflow = ovf_q;
endmodule

// File: tb/tb_multi_stage_stopwatch.sv
// Scoreboard bench for multi_stage_stopwatch (DIV_MAX=5, LIM=5).
// Expectations queued by stimulus, compared by a negedge monitor.
module tb_multi_stage_stopwatch;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst_hw;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multi_stage_stopwatch_if #(.W(W)) sw ();

  multi_stage_stopwatch #(
    .DIV_MAX(5),
    .W(W),
    .LIM0(5),
    .LIM1(5),
    .LIM2(5)
  ) dut (
    .clk(clk),
    .rst_hw(rst_hw),
    .sw(sw)
  );

  typedef struct {
    string        name;
    logic [W-1:0] q0, q1, q2;
    logic [1:0]   st;
    logic         ov;
    logic [W-1:0] l0, l1, l2;
    logic         lv;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] cur_l0 = '0, cur_l1 = '0, cur_l2 = '0;
  logic         cur_lv = 1'b0;

  task automatic chk(input string n, input int a2, input int a1,
                     input int a0, input int st, input int ov);
    exp_t e;
    e.name = n;
    e.q2 = W'(a2);
    e.q1 = W'(a1);
    e.q0 = W'(a0);
    e.st = 2'(st);
    e.ov = 1'(ov);
    e.l0 = cur_l0;
    e.l1 = cur_l1;
    e.l2 = cur_l2;
    e.lv = cur_lv;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic ok;
      e = sb.pop_front();
      checks++;
      ok = (sw.q0 === e.q0) && (sw.q1 === e.q1) && (sw.q2 === e.q2) &&
           (sw.state === e.st) && (sw.overflow === e.ov);
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
      ok = ok && (sw.lap0 === e.l0) && (sw.lap1 === e.l1) &&
           (sw.lap2 === e.l2) && (sw.lap_valid === e.lv);
      if (!ok)
        $display("FAIL %s: lap got %0d/%0d/%0d v%0d want %0d/%0d/%0d v%0d",
                 e.name, sw.lap2, sw.lap1, sw.lap0, sw.lap_valid,
                 e.l2, e.l1, e.l0, e.lv);
`endif
      if (!ok) begin
        failures++;
        $display("FAIL %s: got q=%0d/%0d/%0d st=%0d ov=%0d want q=%0d/%0d/%0d st=%0d ov=%0d",
                 e.name, sw.q2, sw.q1, sw.q0, sw.state, sw.overflow,
                 e.q2, e.q1, e.q0, e.st, e.ov);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_hw       = 1'b1;
    sw.start     = 1'b0;
    sw.stop      = 1'b0;
    sw.clear     = 1'b0;
    sw.mode_down = 1'b0;
    sw.load      = 1'b0;
    sw.pre0      = '0;
    sw.pre1      = '0;
    sw.pre2      = '0;
`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
    sw.lap       = 1'b0;
`endif
    step(2);
    rst_hw = 1'b0;
    chk("reset", 0, 0, 0, 0, 0);

    sw.start = 1'b1; step(1); sw.start = 1'b0;
    chk("start_run", 0, 0, 0, 1, 0);
    step(5);  chk("first_tick", 0, 0, 1, 1, 0);
    step(20); chk("carry_q1", 0, 1, 0, 1, 0);
    step(15); chk("q0_at_3", 0, 1, 3, 1, 0);

    sw.stop = 1'b1; step(1); sw.stop = 1'b0;
    chk("paused", 0, 1, 3, 2, 0);
    step(100); chk("pause_hold", 0, 1, 3, 2, 0);
    sw.start = 1'b1; step(1); sw.start = 1'b0;
    chk("resume", 0, 1, 3, 1, 0);
    step(3); chk("resume_pre", 0, 1, 3, 1, 0);
    step(1); chk("resume_tick", 0, 1, 4, 1, 0);

    step(575); chk("terminal_up", 4, 4, 4, 1, 0);
    step(1);   chk("lock", 4, 4, 4, 3, 1);
    sw.start = 1'b1; step(1); sw.start = 1'b0;
    sw.stop  = 1'b1; step(1); sw.stop  = 1'b0;
    sw.pre0 = 1; sw.pre1 = 1; sw.pre2 = 1;
    sw.load  = 1'b1; step(1); sw.load  = 1'b0;
    chk("lock_ignore", 4, 4, 4, 3, 1);
    sw.clear = 1'b1; step(1); sw.clear = 1'b0;
    chk("clear_lock", 0, 0, 0, 0, 0);

    sw.mode_down = 1'b1;
    sw.pre0 = 0; sw.pre1 = 0; sw.pre2 = 2;
    sw.load = 1'b1; step(1); sw.load = 1'b0;
    chk("load_down", 2, 0, 0, 0, 0);
    sw.start = 1'b1; step(1); sw.start = 1'b0;
    sw.mode_down = 1'b0;
    chk("down_run", 2, 0, 0, 1, 0);
    step(5);   chk("borrow", 1, 4, 4, 1, 0);
    step(245); chk("down_zero", 0, 0, 0, 1, 0);
    step(1);   chk("down_lock", 0, 0, 0, 3, 1);
    sw.clear = 1'b1; step(1); sw.clear = 1'b0;
    chk("clear_down", 0, 0, 0, 0, 0);

    sw.mode_down = 1'b1;
    sw.start = 1'b1; step(1); sw.start = 1'b0;
    sw.mode_down = 1'b0;
    chk("start_term", 0, 0, 0, 1, 0);
    step(1);  chk("term_lock", 0, 0, 0, 3, 1);
    step(10); chk("term_hold", 0, 0, 0, 3, 1);
    sw.clear = 1'b1; step(1); sw.clear = 1'b0;
    chk("clear_term", 0, 0, 0, 0, 0);

    sw.start = 1'b1; step(1); sw.start = 1'b0;
    step(5); chk("run2", 0, 0, 1, 1, 0);
    sw.clear = 1'b1; sw.stop = 1'b1; sw.start = 1'b1;
    step(1);
    sw.clear = 1'b0; sw.stop = 1'b0; sw.start = 1'b0;
    chk("clr_prio", 0, 0, 0, 0, 0);
    sw.pre0 = 9; sw.pre1 = 3; sw.pre2 = 7;
    sw.load = 1'b1; step(1); sw.load = 1'b0;
    chk("clamp", 4, 3, 4, 0, 0);
    sw.clear = 1'b1; step(1); sw.clear = 1'b0;
    chk("clear_clamp", 0, 0, 0, 0, 0);

    sw.start = 1'b1; step(1); sw.start = 1'b0;
    step(4);
    sw.stop = 1'b1; step(1); sw.stop = 1'b0;
    chk("stop_tick", 0, 0, 1, 2, 0);
    sw.start = 1'b1; step(1); sw.start = 1'b0;
    chk("resume2", 0, 0, 1, 1, 0);
    step(4);
    rst_hw = 1'b1; sw.stop = 1'b1; step(1);
    rst_hw = 1'b0; sw.stop = 1'b0;
    chk("rst_mid", 0, 0, 0, 0, 0);

`ifdef MULTI_STAGE_STOPWATCH_LAP_EN
    sw.lap = 1'b1; step(1); sw.lap = 1'b0;
    chk("lap_idle", 0, 0, 0, 0, 0);
    sw.start = 1'b1; step(1); sw.start = 1'b0;
    step(10); chk("lap_pre", 0, 0, 2, 1, 0);
    sw.lap = 1'b1; step(1); sw.lap = 1'b0;
    cur_l0 = 2; cur_lv = 1'b1;
    chk("lap_cap", 0, 0, 2, 1, 0);
    step(4); chk("lap_hold", 0, 0, 3, 1, 0);
    sw.clear = 1'b1; step(1); sw.clear = 1'b0;
    cur_l0 = 0; cur_lv = 1'b0;
    chk("lap_clr", 0, 0, 0, 0, 0);
`endif

    step(2);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
